io_mouse_fifo: RTL
==================

Name: io_mouse_fifo

Overview:
- Memory-mapped mouse peripheral for the 8-bit processor bus; parametrised successor of the single-snapshot mouse IO block.
- Buffers complete mouse packets (status, X, Y, Z) from the mouse transceiver in a DEPTH-entry FIFO, so the CPU cannot miss packets between interrupts.
- Adds a control register, FIFO flags/count, a pop register, a selectable overflow policy and a maskable interrupt.

Parameters:
- BASE_ADDR, 8'hA0, first bus address of the register window.
- DEPTH, 8, FIFO entries; power of two, 2..64.
- PTR_W, 3, log2(DEPTH).

Ports:
- CLK  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- BUS_DATA  inout  8  shared data bus; driven only during a read of this window, else high-Z
- BUS_ADDR  in  8  bus address
- BUS_WE  in  1  1 = CPU write, 0 = read
- PKT_VALID  in  1  one-cycle strobe from transceiver: new packet on PKT_* this cycle
- PKT_STATUS  in  4  packet status nibble
- PKT_X  in  8  X movement
- PKT_Y  in  8  Y movement
- PKT_Z  in  8  Z/wheel movement
- BUS_INTERRUPT_RAISE  out  1  interrupt request
- BUS_INTERRUPT_ACK  in  1  interrupt acknowledge from CPU

Behaviour:
- Register map (offset from BASE_ADDR):
  - 0 R: head status, {4'b0, status}
  - 1 R: head X
  - 2 R: head Y
  - 3 R: head Z
  - 4 R: count, 0..DEPTH
  - 5 R/W: CTRL; bit0 IE, bit1 OVWR, bit2 CLR (write-only, self-clearing, reads 0)
  - 6 W: POP; any written value pops the head
  - 7 R/W: FLAGS; bit0 EMPTY, bit1 FULL, bit2 OVF sticky. Writing 1 to bit2 clears OVF.
  - Head reads with FIFO empty return 8'h00.
- Decode: address in [BASE_ADDR, BASE_ADDR+8). Window is 9 bytes with the optional feature.
- Read timing:
  - Cycle N: address presented with BUS_WE=0.
  - Cycle N+1: output register holds the data and the bus is driven.
  - Drive enable drops the cycle after the address leaves the window or BUS_WE=1.
  - Reads have no side effects.
- Writes take effect at the clock edge of the addressed cycle. Writes to read-only offsets are ignored.
- Push (PKT_VALID=1), by state:
  - Not full: store the entry at the write pointer; increment pointer and count.
  - Full, OVWR=0: drop the new packet; set OVF.
  - Full, OVWR=1: overwrite the oldest entry; advance both pointers; count stays DEPTH; set OVF.
- Pop, by state:
  - Not empty: advance the read pointer; decrement count.
  - Empty: ignored.
- Simultaneous events:
  - Push and pop, FIFO full: both proceed; count unchanged; no OVF.
  - Push and pop, FIFO empty: push only.
  - CLR with push or pop: CLR wins. Pointers and count go to 0 and the packet is discarded. CLR does not clear OVF.
- Pointers wrap modulo DEPTH.
- Interrupt flag:
  - Set on any accepted or overwriting push while IE=1.
  - Cleared by BUS_INTERRUPT_ACK.
  - Push and ACK in the same cycle: set wins.
  - Writing IE=0 clears the flag.
- Reset values:
  - BUS_INTERRUPT_RAISE = 0; bus drive off; output register = 0.
  - Pointers and count = 0; CTRL = 0; OVF = 0.
  - Entry contents are don't-care.
  - Reset mid-transfer releases the bus on the next edge.

Optional Feature:
- Macro: IO_MOUSE_TIMESTAMP_EN.
- Defined:
  - A 16-bit prescaler plus an 8-bit free-running tick counter advance once every 65536 clocks.
  - The tick value is stored with each entry.
  - Offset 8 (R) returns the head timestamp; the window is 9 bytes.
  - Reset clears both counters.
- Undefined:
  - No counters or timestamp storage.
  - Offset 8 is outside the window; the bus is not driven there.

Test Plan:
- Reset, then read offsets 7 and 4 → 8'h01 (EMPTY) and 8'h00; BUS_INTERRUPT_RAISE=0; BUS_DATA high-Z with address 8'h50.
- Write CTRL=8'h01; push packet (4'h9, 8'h05, 8'hFB, 8'h01); read 0..3 → 8'h09, 8'h05, 8'hFB, 8'h01 one cycle after each address; IRQ=1; pulse ACK → IRQ=0; write POP → count 0, EMPTY=1.
- OVWR=0: push 9 packets with X=1..9 → count 8, FLAGS=8'h06, head X=1. OVWR=1: one more push with X=10 → head X=2, count 8. Write FLAGS=8'h04 → OVF cleared.
- Full FIFO, push X=20 and pop in the same cycle → count 8, OVF unchanged (0), head advanced, newest entry X=20. Empty FIFO, push and pop together → count 1.
- Push 3 packets, then write CTRL=8'h05 (IE plus CLR) in the same cycle as PKT_VALID → count 0, EMPTY=1, CTRL reads 8'h01; ACK in the same cycle as a push → IRQ stays 1.
- With IO_MOUSE_TIMESTAMP_EN: push, run 2×65536 clocks, push, pop, read offset 8 → 8'h02. Without the macro: reading BASE_ADDR+8 leaves BUS_DATA high-Z.

Source files
------------

// File: rtl/io_mouse_fifo.sv
// io_mouse_fifo
//   Memory-mapped mouse peripheral for the 8-bit processor bus. Complete
//   mouse packets (status, X, Y, Z) from the transceiver are queued in a
//   DEPTH-entry FIFO. The CPU reads the head entry, pops it, and watches
//   the count and flags. A selectable overflow policy either drops new
//   packets or overwrites the oldest one. A maskable interrupt is raised
//   on every push that lands in the FIFO.
//
//   Optional build macro: IO_MOUSE_TIMESTAMP_EN
//     Stores an 8-bit tick value with each entry. The tick advances once
//     every 65536 clocks. The head timestamp is readable at offset 8.
//
//   Register window (offset from BASE_ADDR):
//     0 R   head status {4'b0, status}    1 R  head X
//     2 R   head Y                        3 R  head Z
//     4 R   count (0..DEPTH)
//     5 R/W CTRL  bit0 IE, bit1 OVWR, bit2 CLR (write-only, reads 0)
//     6 W   POP   (any value)
//     7 R/W FLAGS bit0 EMPTY, bit1 FULL, bit2 OVF (write 1 to clear)
//     8 R   head timestamp (only with IO_MOUSE_TIMESTAMP_EN)
//
//   Ports:
//     CLK                 system clock
//     RESET               synchronous, active-high reset
//     BUS_DATA   [7:0]    shared data bus, driven only for reads of this window
//     BUS_ADDR   [7:0]    bus address
//     BUS_WE              1 = CPU write, 0 = read
//     PKT_VALID           one-cycle strobe, new packet on PKT_*
//     PKT_STATUS [3:0]    packet status nibble
//     PKT_X/Y/Z  [7:0]    movement bytes
//     BUS_INTERRUPT_RAISE interrupt request
//     BUS_INTERRUPT_ACK   interrupt acknowledge
module io_mouse_fifo #(
  parameter logic [7:0]  BASE_ADDR = 8'hA0,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned PTR_W     = 3
) (
  input  logic       CLK,
  input  logic       RESET,
  inout  wire  [7:0] BUS_DATA,
  input  logic [7:0] BUS_ADDR,
  input  logic       BUS_WE,
  input  logic       PKT_VALID,
  input  logic [3:0] PKT_STATUS,
  input  logic [7:0] PKT_X,
  input  logic [7:0] PKT_Y,
  input  logic [7:0] PKT_Z,
  output logic       BUS_INTERRUPT_RAISE,
  input  logic       BUS_INTERRUPT_ACK
);

`ifdef IO_MOUSE_TIMESTAMP_EN
  localparam logic [7:0] WIN_SIZE = 8'd9;
`else
  localparam logic [7:0] WIN_SIZE = 8'd8;
`endif
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  localparam logic [7:0] OFF_STATUS = 8'd0;
  localparam logic [7:0] OFF_X      = 8'd1;
  localparam logic [7:0] OFF_Y      = 8'd2;
  localparam logic [7:0] OFF_Z      = 8'd3;
  localparam logic [7:0] OFF_COUNT  = 8'd4;
  localparam logic [7:0] OFF_CTRL   = 8'd5;
  localparam logic [7:0] OFF_POP    = 8'd6;
  localparam logic [7:0] OFF_FLAGS  = 8'd7;

  // Entry storage (no reset: contents are don't-care until written)
  logic [3:0] r_st [DEPTH];
  logic [7:0] r_x  [DEPTH];
  logic [7:0] r_y  [DEPTH];
  logic [7:0] r_z  [DEPTH];

  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [PTR_W:0]   r_count;
  logic             r_ie;
  logic             r_ovwr;
  logic             r_ovf;
  logic             r_irq;
  logic [7:0]       r_rd_data;
  logic             r_drive;

  logic [7:0] w_off;
  logic       w_in_win;
  logic       w_rd_sel;
  logic       w_wr_sel;
  logic       w_ctrl_wr;
  logic       w_pop_req;
  logic       w_flags_wr;
  logic       w_clr;
  logic       w_empty;
  logic       w_full;
  logic       w_pop_ok;
  logic       w_store;
  logic       w_ovf_set;
  logic       w_rd_adv;
  logic [7:0] w_rd_mux;
  logic       w_unused_bus;

  assign w_off      = BUS_ADDR - BASE_ADDR;
  assign w_in_win   = (w_off < WIN_SIZE);
  assign w_rd_sel   = w_in_win && !BUS_WE;
  assign w_wr_sel   = w_in_win && BUS_WE;
  assign w_ctrl_wr  = w_wr_sel && (w_off == OFF_CTRL);
  assign w_pop_req  = w_wr_sel && (w_off == OFF_POP);
  assign w_flags_wr = w_wr_sel && (w_off == OFF_FLAGS);
  assign w_clr      = w_ctrl_wr && BUS_DATA[2];
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == FULL_CNT);

  assign w_unused_bus = &{1'b0, BUS_DATA[7:3]};

  // CLR suppresses both push and pop in its cycle. A pop on a full FIFO
  // frees the slot for a simultaneous push, so that case never overflows.
  // When full, the write pointer equals the read pointer, so an
  // overwriting push lands on the oldest entry and both pointers advance.
  assign w_pop_ok  = w_pop_req && !w_empty && !w_clr;
  assign w_store   = PKT_VALID && !w_clr && (!w_full || w_pop_ok || r_ovwr);
  assign w_ovf_set = PKT_VALID && !w_clr && w_full && !w_pop_ok;
  assign w_rd_adv  = w_pop_ok || (w_ovf_set && r_ovwr);

  assign BUS_DATA            = r_drive ? r_rd_data : 8'hzz;
  assign BUS_INTERRUPT_RAISE = r_irq;

`ifdef IO_MOUSE_TIMESTAMP_EN
  logic [15:0] r_presc;
  logic [7:0]  r_tick;
  logic [7:0]  r_ts [DEPTH];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_presc <= '0;
      r_tick  <= '0;
    end else begin
      r_presc <= r_presc + 16'd1;
      if (r_presc == '1) r_tick <= r_tick + 8'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_store) r_ts[r_wptr] <= r_tick;
  end
`endif

  always_comb begin
    w_rd_mux = '0;
    case (w_off)
      OFF_STATUS: if (!w_empty) w_rd_mux = {4'b0, r_st[r_rptr]};
      OFF_X:      if (!w_empty) w_rd_mux = r_x[r_rptr];
      OFF_Y:      if (!w_empty) w_rd_mux = r_y[r_rptr];
      OFF_Z:      if (!w_empty) w_rd_mux = r_z[r_rptr];
      OFF_COUNT:  w_rd_mux = 8'(r_count);
      OFF_CTRL:   w_rd_mux = {6'b0, r_ovwr, r_ie};
      OFF_FLAGS:  w_rd_mux = {5'b0, r_ovf, w_full, w_empty};
`ifdef IO_MOUSE_TIMESTAMP_EN
      8'd8:       if (!w_empty) w_rd_mux = r_ts[r_rptr];
`endif
      default:    w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (w_store) begin
      r_st[r_wptr] <= PKT_STATUS;
      r_x[r_wptr]  <= PKT_X;
      r_y[r_wptr]  <= PKT_Y;
      r_z[r_wptr]  <= PKT_Z;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_ie      <= 1'b0;
      r_ovwr    <= 1'b0;
      r_ovf     <= 1'b0;
      r_irq     <= 1'b0;
      r_rd_data <= '0;
      r_drive   <= 1'b0;
    end else begin
      if (w_clr) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
      end else begin
        if (w_store)  r_wptr <= r_wptr + 1'b1;
        if (w_rd_adv) r_rptr <= r_rptr + 1'b1;
        if (w_store && !w_rd_adv)      r_count <= r_count + 1'b1;
        else if (!w_store && w_rd_adv) r_count <= r_count - 1'b1;
      end

      if (w_ctrl_wr) begin
        r_ie   <= BUS_DATA[0];
        r_ovwr <= BUS_DATA[1];
      end

      // A new overflow event takes priority over a same-cycle clear
      if (w_ovf_set)                       r_ovf <= 1'b1;
      else if (w_flags_wr && BUS_DATA[2])  r_ovf <= 1'b0;

      if (w_ctrl_wr && !BUS_DATA[0])       r_irq <= 1'b0;
      else if (w_store && r_ie)            r_irq <= 1'b1;
      else if (BUS_INTERRUPT_ACK)          r_irq <= 1'b0;

      r_drive <= w_rd_sel;
      if (w_rd_sel) r_rd_data <= w_rd_mux;
    end
  end

endmodule
